order_hash_table: RTL

Parametrised successor to the first-generation order map. It stores every live order, keyed by reference number, in a hash table that uses linear probing. It supports three operations, add, delete and execute, and each operation returns the stored locate, price, remaining shares and side to the book builder downstream. Per-slot EMPTY/VALID/TOMB status bits replace the "reference number == 0 means free" convention, so deletes and full executes free slots correctly.

---
 rtl/order_hash_table_pkg.sv | 36 +++
 rtl/order_hash_ram.sv | 26 ++
 rtl/order_hash_table.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/order_hash_table_pkg.sv
// Shared types for the order hash table: command opcodes, slot status and the stored entry.
// Reference numbers up to RefMaxW bits are supported; narrower refs are zero-extended.
package order_hash_table_pkg;

  localparam int unsigned RefMaxW = 64;

  typedef enum logic [1:0] {
    OP_ADD  = 2'd0,
    OP_DEL  = 2'd1,
    OP_EXEC = 2'd2
  } orderOpType;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    VALID = 2'd1,
    TOMB  = 2'd2
  } slotStateType;

  typedef struct packed {
    logic [RefMaxW-1:0] ref_num;
    logic [15:0]        locate;
    logic [31:0]        price;
    logic [31:0]        shares;
    logic               side;
  } orderEntryType;

  localparam int unsigned EntryW = $bits(orderEntryType);

  typedef enum logic [1:0] {
    StIdle,
    StRd,
    StCmp,
    StWr
  } fsm_state_e;

endpackage

// File: rtl/order_hash_ram.sv
// Single-port synchronous RAM with a one-cycle registered read.
// A write returns the old contents on the read port (no write-first bypass).
module order_hash_ram #(
  parameter int unsigned Depth = 4096,
  parameter int unsigned Width = 145
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [$clog2(Depth)-1:0] addr_i,
  input  logic [Width-1:0]         wdata_i,
  output logic [Width-1:0]         rdata_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
    rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/order_hash_table.sv
// Linear-probing hash table of live orders with add / delete / execute commands.
// Define ORDER_HASH_STATS_EN to build the probe high-water and rejected-add counters.
module order_hash_table
  import order_hash_table_pkg::*;
#(
  parameter int unsigned DEPTH     = 4096,
  parameter int unsigned MAX_PROBE = 8,
  parameter int unsigned REF_WIDTH = 64
) (
  input  logic                       clkIn,
  input  logic                       rstNIn,
  input  logic                       cmdValidIn,
  output logic                       cmdReadyOut,
  input  logic [1:0]                 cmdOpIn,
  input  logic [REF_WIDTH-1:0]       refNumIn,
  input  logic [15:0]                locateIn,
  input  logic [31:0]                priceIn,
  input  logic [31:0]                sharesIn,
  input  logic                       buySellIn,
  output logic                       respValidOut,
  output logic [1:0]                 respOpOut,
  output logic                       foundOut,
  output logic                       errOut,
  output logic [15:0]                locateOut,
  output logic [31:0]                priceOut,
  output logic [31:0]                sharesOut,
  output logic                       buySellOut,
  output logic [$clog2(MAX_PROBE):0] probeCntOut,
  output logic [$clog2(DEPTH):0]     occupancyOut,
  output logic                       fullOut,
  output logic [$clog2(MAX_PROBE):0] statMaxProbeOut,
  output logic [31:0]                statRejectOut
);

  localparam int unsigned AW      = $clog2(DEPTH);
  localparam int unsigned PW      = $clog2(MAX_PROBE) + 1;
  localparam int unsigned OW      = AW + 1;
  localparam int unsigned NChunks = (REF_WIDTH + AW - 1) / AW;
  localparam int unsigned PadW    = NChunks * AW;

  function automatic logic [AW-1:0] fold_hash(input logic [REF_WIDTH-1:0] r);
    logic [PadW-1:0] padded;
    logic [AW-1:0]   h;
    padded = PadW'(r);
    h      = '0;
    for (int c = 0; c < NChunks; c++) begin
      h ^= padded[c*AW +: AW];
    end
    return h;
  endfunction

  fsm_state_e           state_q, state_d;
  orderOpType           op_q, op_d;
  logic [REF_WIDTH-1:0] ref_q, ref_d;
  logic [15:0]          loc_q, loc_d;
  logic [31:0]          price_q, price_d;
  logic [31:0]          shares_q, shares_d;
  logic                 side_q, side_d;
  logic [AW-1:0]        idx_q, idx_d;
  logic [PW-1:0]        k_q, k_d;
  logic                 hit_q, hit_d;
  logic [OW-1:0]        occ_q, occ_d;

  logic                 resp_valid_q, resp_valid_d;
  logic [1:0]           resp_op_q, resp_op_d;
  logic                 resp_found_q, resp_found_d;
  logic                 resp_err_q, resp_err_d;
  logic [15:0]          resp_loc_q, resp_loc_d;
  logic [31:0]          resp_price_q, resp_price_d;
  logic [31:0]          resp_shares_q, resp_shares_d;
  logic                 resp_side_q, resp_side_d;
  logic [PW-1:0]        resp_probe_q, resp_probe_d;

  slotStateType         status_q [DEPTH];
  logic                 status_we;
  slotStateType         status_wval;

  logic                 ram_we;
  orderEntryType        ram_wdata;
  logic [EntryW-1:0]    ram_rdata;
  orderEntryType        rd_entry;

  slotStateType         cur_st;
  logic                 ref_match, exhausted, probe_hit, probe_stop;
  logic [31:0]          exec_rem;

  order_hash_ram #(
    .Depth (DEPTH),
    .Width (EntryW)
  ) u_ram (
    .clk_i   (clkIn),
    .we_i    (ram_we),
    .addr_i  (idx_q),
    .wdata_i (ram_wdata),
    .rdata_o (ram_rdata)
  );

  assign rd_entry  = orderEntryType'(ram_rdata);
  assign cur_st    = status_q[idx_q];
  assign ref_match = (rd_entry.ref_num == RefMaxW'(ref_q));
  assign exhausted = (k_q == PW'(MAX_PROBE));
  assign exec_rem  = (rd_entry.shares > shares_q) ? (rd_entry.shares - shares_q) : 32'd0;

  // Adds take the first non-VALID slot; lookups stop on a key match or on an EMPTY slot.
  assign probe_hit  = (op_q == OP_ADD) ? (cur_st != VALID) : ((cur_st == VALID) && ref_match);
  assign probe_stop = probe_hit || ((op_q != OP_ADD) && (cur_st == EMPTY)) || exhausted;

  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    ref_d         = ref_q;
    loc_d         = loc_q;
    price_d       = price_q;
    shares_d      = shares_q;
    side_d        = side_q;
    idx_d         = idx_q;
    k_d           = k_q;
    hit_d         = hit_q;
    occ_d         = occ_q;
    resp_valid_d  = 1'b0;
    resp_op_d     = resp_op_q;
    resp_found_d  = resp_found_q;
    resp_err_d    = resp_err_q;
    resp_loc_d    = resp_loc_q;
    resp_price_d  = resp_price_q;
    resp_shares_d = resp_shares_q;
    resp_side_d   = resp_side_q;
    resp_probe_d  = resp_probe_q;
    status_we     = 1'b0;
    status_wval   = EMPTY;
    ram_we        = 1'b0;
    ram_wdata     = '0;

    unique case (state_q)
      StIdle: begin
        if (cmdValidIn) begin
          op_d     = orderOpType'(cmdOpIn);
          ref_d    = refNumIn;
          loc_d    = locateIn;
          price_d  = priceIn;
          shares_d = sharesIn;
          side_d   = buySellIn;
          idx_d    = fold_hash(refNumIn);
          k_d      = PW'(1);
          state_d  = StRd;
        end
      end
      StRd: state_d = StCmp;
      StCmp: begin
        if (probe_stop) begin
          hit_d   = probe_hit;
          state_d = StWr;
        end else begin
          idx_d   = idx_q + AW'(1);
          k_d     = k_q + PW'(1);
          state_d = StRd;
        end
      end
      StWr: begin
        state_d       = StIdle;
        resp_valid_d  = 1'b1;
        resp_op_d     = op_q;
        resp_probe_d  = k_q;
        resp_found_d  = 1'b0;
        resp_err_d    = (op_q == OP_ADD) && !hit_q;
        resp_loc_d    = '0;
        resp_price_d  = '0;
        resp_shares_d = '0;
        resp_side_d   = 1'b0;
        if (hit_q) begin
          unique case (op_q)
            OP_ADD: begin
              ram_we        = 1'b1;
              ram_wdata     = '{ref_num: RefMaxW'(ref_q), locate: loc_q, price: price_q,
                                shares: shares_q, side: side_q};
              status_we     = 1'b1;
              status_wval   = VALID;
              occ_d         = occ_q + OW'(1);
              resp_found_d  = 1'b1;
              resp_loc_d    = loc_q;
              resp_price_d  = price_q;
              resp_shares_d = shares_q;
              resp_side_d   = side_q;
            end
            OP_DEL: begin
              status_we     = 1'b1;
              status_wval   = TOMB;
              occ_d         = occ_q - OW'(1);
              resp_found_d  = 1'b1;
              resp_loc_d    = rd_entry.locate;
              resp_price_d  = rd_entry.price;
              resp_side_d   = rd_entry.side;
            end
            OP_EXEC: begin
              resp_found_d  = 1'b1;
              resp_loc_d    = rd_entry.locate;
              resp_price_d  = rd_entry.price;
              resp_side_d   = rd_entry.side;
              resp_shares_d = exec_rem;
              if (exec_rem == 32'd0) begin
                status_we   = 1'b1;
                status_wval = TOMB;
                occ_d       = occ_q - OW'(1);
              end else begin
                ram_we           = 1'b1;
                ram_wdata        = rd_entry;
                ram_wdata.shares = exec_rem;
              end
            end
            default: ;
          endcase
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clkIn or negedge rstNIn) begin
    if (!rstNIn) begin
      state_q       <= StIdle;
      op_q          <= OP_ADD;
      ref_q         <= '0;
      loc_q         <= '0;
      price_q       <= '0;
      shares_q      <= '0;
      side_q        <= 1'b0;
      idx_q         <= '0;
      k_q           <= '0;
      hit_q         <= 1'b0;
      occ_q         <= '0;
      resp_valid_q  <= 1'b0;
      resp_op_q     <= '0;
      resp_found_q  <= 1'b0;
      resp_err_q    <= 1'b0;
      resp_loc_q    <= '0;
      resp_price_q  <= '0;
      resp_shares_q <= '0;
      resp_side_q   <= 1'b0;
      resp_probe_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        status_q[i] <= EMPTY;
      end
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      ref_q         <= ref_d;
      loc_q         <= loc_d;
      price_q       <= price_d;
      shares_q      <= shares_d;
      side_q        <= side_d;
      idx_q         <= idx_d;
      k_q           <= k_d;
      hit_q         <= hit_d;
      occ_q         <= occ_d;
      resp_valid_q  <= resp_valid_d;
      resp_op_q     <= resp_op_d;
      resp_found_q  <= resp_found_d;
      resp_err_q    <= resp_err_d;
      resp_loc_q    <= resp_loc_d;
      resp_price_q  <= resp_price_d;
      resp_shares_q <= resp_shares_d;
      resp_side_q   <= resp_side_d;
      resp_probe_q  <= resp_probe_d;
      if (status_we) begin
        status_q[idx_q] <= status_wval;
      end
    end
  end

  assign cmdReadyOut  = (state_q == StIdle);
  assign respValidOut = resp_valid_q;
  assign respOpOut    = resp_op_q;
  assign foundOut     = resp_found_q;
  assign errOut       = resp_err_q;
  assign locateOut    = resp_loc_q;
  assign priceOut     = resp_price_q;
  assign sharesOut    = resp_shares_q;
  assign buySellOut   = resp_side_q;
  assign probeCntOut  = resp_probe_q;
  assign occupancyOut = occ_q;
  assign fullOut      = (occ_q == OW'(DEPTH));

`ifdef ORDER_HASH_STATS_EN
  logic [PW-1:0] stat_max_q, stat_max_d;
  logic [31:0]   stat_rej_q, stat_rej_d;

  always_comb begin
    stat_max_d = stat_max_q;
    stat_rej_d = stat_rej_q;
    if (state_q == StWr) begin
      if (k_q > stat_max_q) begin
        stat_max_d = k_q;
      end
      if ((op_q == OP_ADD) && !hit_q && (stat_rej_q != '1)) begin
        stat_rej_d = stat_rej_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clkIn or negedge rstNIn) begin
    if (!rstNIn) begin
      stat_max_q <= '0;
      stat_rej_q <= '0;
    end else begin
      stat_max_q <= stat_max_d;
      stat_rej_q <= stat_rej_d;
    end
  end

  assign statMaxProbeOut = stat_max_q;
  assign statRejectOut   = stat_rej_q;
`else
  assign statMaxProbeOut = '0;
  assign statRejectOut   = '0;
`endif

endmodule
